// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and FSM state encodings for the single-beat master.
package axi_lite_pkg;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef logic [AXI_ADDR_W-1:0] addr_t;
    typedef logic [AXI_DATA_W-1:0] data_t;
    typedef logic [AXI_STRB_W-1:0] strb_t;
    typedef logic [2:0]            prot_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        WR_IDLE      = 2'd0,
        WR_ADDR_DATA = 2'd1,
        WR_WAIT_B    = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ADDR   = 2'd1,
        RD_WAIT_R = 2'd2
    } rd_state_t;

    localparam prot_t PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/axi_lite_rd_fsm.sv
// Read path of the AXI4-Lite master: AR address phase, then R data capture.
// Watchdog abort is compiled in only with AXI_LITE_TIMEOUT_EN.
module axi_lite_rd_fsm
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef AXI_LITE_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 256
`endif
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        resp,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [1:0]        state
);
    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        resp_q;
    logic              done_q;
    logic              accept, ar_hs, r_hs, timeout;

    assign accept = start && !busy;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;

`ifdef AXI_LITE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else if (state_q == RD_IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // A response arriving in the final cycle still wins over the abort.
    assign timeout = (state_q != RD_IDLE) && (cnt_q == CNT_W'(TIMEOUT - 1)) && !r_hs;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE:   if (accept) state_d = RD_ADDR;
            RD_ADDR:   if (ar_hs)  state_d = RD_WAIT_R;
            RD_WAIT_R: if (r_hs)   state_d = RD_IDLE;
            default:               state_d = RD_IDLE;
        endcase
        if (timeout) state_d = RD_IDLE;
    end

    always_comb begin
        arvalid = (state_q == RD_ADDR);
        rready  = (state_q == RD_WAIT_R);
        busy    = (state_q != RD_IDLE) || done_q;
        done    = done_q;
        resp    = resp_q;
        rd_data = data_q;
        araddr  = addr_q;
        arprot  = PROT_DEFAULT;
        state   = state_q;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q <= '0;
            data_q <= '0;
            resp_q <= OKAY;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) addr_q <= addr;
            if (r_hs) begin
                data_q <= rdata;
                resp_q <= rresp;
                done_q <= 1'b1;
            end else if (timeout) begin
                resp_q <= SLVERR;
                done_q <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_lite_if_master.sv
// AXI4-Lite single-beat master: start pulses launch one write and/or one read each.
// Define AXI_LITE_TIMEOUT_EN to add a per-path watchdog that aborts with SLVERR.
module axi_lite_if_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef AXI_LITE_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 256
`endif
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start_write,
    input  logic                start_read,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    output logic                wr_busy,
    output logic                rd_busy,
    output logic                wr_done,
    output logic                rd_done,
    output logic [1:0]          wr_resp,
    output logic [1:0]          rd_resp,
    output logic [DATA_W-1:0]   rd_data,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [1:0]          wr_state,
    output logic [1:0]          rd_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready. Valid and its
    // payload come only from registers, never from ready, and hold until that edge.
    wr_state_t         wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [1:0]        wr_resp_q;
    logic              wr_done_q, aw_done_q, w_done_q;
    logic              wr_accept, aw_hs, w_hs, b_hs, wr_timeout;

    assign wr_accept = start_write && !wr_busy;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign b_hs      = bvalid && bready;

`ifdef AXI_LITE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wr_cnt_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_cnt_q <= '0;
        end else if (wr_state_q == WR_IDLE) begin
            wr_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        end
    end

    assign wr_timeout = (wr_state_q != WR_IDLE) && (wr_cnt_q == CNT_W'(TIMEOUT - 1)) && !b_hs;
`else
    assign wr_timeout = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= WR_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    // AW and W complete independently; B is awaited once both have been accepted.
    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WR_IDLE:      if (wr_accept) wr_state_d = WR_ADDR_DATA;
            WR_ADDR_DATA: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wr_state_d = WR_WAIT_B;
            WR_WAIT_B:    if (b_hs) wr_state_d = WR_IDLE;
            default:      wr_state_d = WR_IDLE;
        endcase
        if (wr_timeout) wr_state_d = WR_IDLE;
    end

    always_comb begin
        awvalid  = (wr_state_q == WR_ADDR_DATA) && !aw_done_q;
        wvalid   = (wr_state_q == WR_ADDR_DATA) && !w_done_q;
        bready   = (wr_state_q == WR_WAIT_B);
        wr_busy  = (wr_state_q != WR_IDLE) || wr_done_q;
        wr_done  = wr_done_q;
        wr_resp  = wr_resp_q;
        awaddr   = wr_addr_q;
        wdata    = wr_data_q;
        awprot   = PROT_DEFAULT;
        wstrb    = '1;
        wr_state = wr_state_q;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_resp_q <= OKAY;
            wr_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            if (wr_accept) begin
                wr_addr_q <= addr;
                wr_data_q <= data;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (b_hs) begin
                wr_resp_q <= bresp;
                wr_done_q <= 1'b1;
            end else if (wr_timeout) begin
                wr_resp_q <= SLVERR;
                wr_done_q <= 1'b1;
            end
        end
    end

    axi_lite_rd_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
`ifdef AXI_LITE_TIMEOUT_EN
        ,
        .TIMEOUT(TIMEOUT)
`endif
    ) u_rd_fsm (
        .aclk    (aclk),
        .areset  (areset),
        .start   (start_read),
        .addr    (addr),
        .busy    (rd_busy),
        .done    (rd_done),
        .resp    (rd_resp),
        .rd_data (rd_data),
        .araddr  (araddr),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .state   (rd_state)
    );
endmodule

// File: tb/tb_axi_lite_if_master.sv
// Bench for axi_lite_if_master: register-array slave with programmable ready/response
// delays, a memory/response model with expected queues, and per-cycle output checks.
package tb_pkg;
    localparam int CLOCK_WIDTH = 5;
    localparam int TIMEOUT     = 256;
    localparam int N_RANDOM    = 40;
    localparam int WAIT_BUDGET = 400;
endpackage

module tb_axi_lite_if_master;
    import tb_pkg::*;

    logic        aclk, areset;
    logic        start_write, start_read;
    logic [31:0] addr, data;
    logic        wr_busy, rd_busy, wr_done, rd_done;
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] rd_data;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [1:0]  wr_state, rd_state;

    axi_lite_if_master dut (
        .aclk(aclk), .areset(areset), .start_write(start_write), .start_read(start_read),
        .addr(addr), .data(data), .wr_busy(wr_busy), .rd_busy(rd_busy),
        .wr_done(wr_done), .rd_done(rd_done), .wr_resp(wr_resp), .rd_resp(rd_resp),
        .rd_data(rd_data), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .araddr(araddr), .arprot(arprot),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rready(rready), .wr_state(wr_state), .rd_state(rd_state)
    );

    // ---------------- clock / reset ----------------
    int cyc;
    initial begin
        aclk = 1'b0;
        forever #CLOCK_WIDTH aclk = ~aclk;
    end
    always @(posedge aclk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    int aw_delay, w_delay, b_delay, ar_delay, r_delay;
    bit ar_never;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic have_aw, have_w, have_ar;
    logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
    logic [31:0] mem [0:63];
    bit mem_cleared;
    logic aw_ok, w_ok, ar_ok, b_fire, r_fire;
    logic [31:0] cur_awaddr, cur_wdata, cur_araddr;

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return (a >= 32'h100) ? 2'b11 : 2'b00;
    endfunction

    assign awready    = awvalid && (aw_wait >= aw_delay);
    assign wready     = wvalid && (w_wait >= w_delay);
    assign arready    = arvalid && !ar_never && (ar_wait >= ar_delay);
    assign aw_ok      = have_aw || (awvalid && awready);
    assign w_ok       = have_w || (wvalid && wready);
    assign ar_ok      = have_ar || (arvalid && arready);
    assign cur_awaddr = have_aw ? aw_addr_s : awaddr;
    assign cur_wdata  = have_w ? w_data_s : wdata;
    assign cur_araddr = have_ar ? ar_addr_s : araddr;
    assign b_fire     = aw_ok && w_ok && !bvalid && (b_wait >= b_delay);
    assign r_fire     = ar_ok && !rvalid && (r_wait >= r_delay);

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            have_aw <= 1'b0; have_w <= 1'b0; have_ar <= 1'b0;
            aw_addr_s <= '0; w_data_s <= '0; ar_addr_s <= '0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (awvalid && awready) begin have_aw <= 1'b1; aw_addr_s <= awaddr; end
            if (wvalid && wready)   begin have_w <= 1'b1;  w_data_s <= wdata;   end
            if (arvalid && arready) begin have_ar <= 1'b1; ar_addr_s <= araddr; end
            if (bvalid && bready) bvalid <= 1'b0;
            if (rvalid && rready) rvalid <= 1'b0;
            if (b_fire) begin
                bvalid <= 1'b1; bresp <= resp_of(cur_awaddr);
                have_aw <= 1'b0; have_w <= 1'b0; b_wait <= 0;
            end else if (aw_ok && w_ok && !bvalid) begin
                b_wait <= b_wait + 1;
            end
            if (r_fire) begin
                rvalid <= 1'b1; rresp <= resp_of(cur_araddr);
                rdata  <= (cur_araddr < 32'h100) ? mem[cur_araddr[7:2]] : 32'h0;
                have_ar <= 1'b0; r_wait <= 0;
            end else if (ar_ok && !rvalid) begin
                r_wait <= r_wait + 1;
            end
        end
    end

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            if (!mem_cleared) begin
                for (int i = 0; i < 64; i++) mem[i] <= '0;
                mem_cleared <= 1'b1;
            end
        end else if (b_fire && cur_awaddr < 32'h100) begin
            mem[cur_awaddr[7:2]] <= cur_wdata;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    int errors, checks;
    logic [31:0] model_mem [int];
    logic [1:0]  exp_wr_q[$];
    logic [33:0] exp_rd_q[$];
    logic [31:0] exp_last_rd;
    int wr_start_cyc, rd_start_cyc, wr_done_cyc, rd_done_cyc, wr_done_cnt, rd_done_cnt;
    bit allow_abort;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a >= 32'h100) return 32'h0;
        if (model_mem.exists(int'(a[7:2]))) return model_mem[int'(a[7:2])];
        return 32'h0;
    endfunction

    logic        p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [1:0]  ew;
    logic [33:0] er;

    always @(negedge aclk) begin
        if (areset) begin
            p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
        end else begin
            if (p_awv && !p_awhs && !allow_abort) begin
                check("awvalid_held", awvalid, 1);
                check("awaddr_held", awaddr, p_awaddr);
            end
            if (p_wv && !p_whs && !allow_abort) begin
                check("wvalid_held", wvalid, 1);
                check("wdata_held", wdata, p_wdata);
            end
            if (p_arv && !p_arhs && !allow_abort) begin
                check("arvalid_held", arvalid, 1);
                check("araddr_held", araddr, p_araddr);
            end
            if (awvalid) check("awprot", awprot, 0);
            if (wvalid)  check("wstrb", wstrb, 4'hF);
            if (arvalid) check("arprot", arprot, 0);
            if (wr_done) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_done_unexpected: actual=1 required=0");
                end else begin
                    ew = exp_wr_q.pop_front();
                    checks--;
                    check("wr_resp", wr_resp, ew);
                end
                wr_done_cnt <= wr_done_cnt + 1;
                wr_done_cyc <= cyc;
            end
            if (rd_done) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_done_unexpected: actual=1 required=0");
                end else begin
                    er = exp_rd_q.pop_front();
                    checks--;
                    check("rd_resp", rd_resp, er[33:32]);
                    check("rd_data", rd_data, er[31:0]);
                end
                rd_done_cnt <= rd_done_cnt + 1;
                rd_done_cyc <= cyc;
            end
            p_awv <= awvalid; p_awhs <= awvalid && awready; p_awaddr <= awaddr;
            p_wv  <= wvalid;  p_whs  <= wvalid && wready;   p_wdata  <= wdata;
            p_arv <= arvalid; p_arhs <= arvalid && arready; p_araddr <= araddr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic launch(input bit do_w, input bit do_r, input logic [31:0] a,
                          input logic [31:0] d, input bit dup);
        logic [33:0] e;
        if (do_w) begin
            start_write = 1'b1;
            exp_wr_q.push_back(resp_of(a));
            if (a < 32'h100) model_mem[int'(a[7:2])] = d;
            wr_start_cyc = cyc;
        end
        if (do_r) begin
            start_read = 1'b1;
            e = {resp_of(a), rd_model(a)};
            exp_rd_q.push_back(e);
            exp_last_rd = e[31:0];
            rd_start_cyc = cyc;
        end
        addr = a;
        data = d;
        @(negedge aclk);
        if (do_w) check("wr_busy_after_start", wr_busy, 1);
        if (do_r) check("rd_busy_after_start", rd_busy, 1);
        if (dup) begin
            // Second start while the path is busy must be dropped.
            addr = a ^ 32'h8;
            data = ~d;
            @(negedge aclk);
        end
        start_write = 1'b0;
        start_read  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0) && n < budget) begin
            @(negedge aclk);
            n++;
        end
        check({name, "_wait_budget"}, (n >= budget), 0);
        if (n >= budget) begin
            exp_wr_q.delete();
            exp_rd_q.delete();
        end
        @(negedge aclk);
    endtask

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a, b, d, saved;
        bit saved_ok;
        int mode, cnt0;
        errors = 0; checks = 0; allow_abort = 1'b0; ar_never = 1'b0;
        start_write = 1'b0; start_read = 1'b0; addr = '0; data = '0;
        exp_last_rd = '0;
        set_delays(0, 0, 0, 0, 0);
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_busy", {wr_busy, rd_busy}, 0);
        check("rst_done", {wr_done, rd_done}, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_resp", {wr_resp, rd_resp}, 0);
        areset = 1'b0;
        @(negedge aclk);

        // Zero-wait write then read of the same word.
        launch(1, 0, 32'h10, 32'hDEADBEEF, 0);
        wait_idle("t1", WAIT_BUDGET);
        check("t1_wr_latency", wr_done_cyc - wr_start_cyc, 3);
        check("t1_wr_resp_lit", wr_resp, 2'b00);
        check("t1_busy_cleared", wr_busy, 0);
        launch(0, 1, 32'h10, 32'h0, 0);
        wait_idle("t2", WAIT_BUDGET);
        check("t2_rd_latency", rd_done_cyc - rd_start_cyc, 3);
        check("t2_rd_data_lit", rd_data, 32'hDEADBEEF);
        check("t2_rd_resp_lit", rd_resp, 2'b00);

        // W accepted four cycles after AW.
        set_delays(0, 4, 0, 0, 0);
        cnt0 = wr_done_cnt;
        launch(1, 0, 32'h30, 32'h12345678, 0);
        wait_idle("t3", WAIT_BUDGET);
        repeat (3) @(negedge aclk);
        check("t3_wr_latency", wr_done_cyc - wr_start_cyc, 7);
        check("t3_single_done", wr_done_cnt - cnt0, 1);
        set_delays(0, 0, 0, 0, 0);
        launch(0, 1, 32'h30, 32'h0, 0);
        wait_idle("t3r", WAIT_BUDGET);

        // Same-cycle starts share the addr port; AR is held off so the read sees the new word.
        set_delays(0, 0, 0, 6, 0);
        launch(1, 1, 32'h24, 32'h5A5A5A5A, 0);
        wait_idle("t4", WAIT_BUDGET);
        check("t4_rd_data_lit", rd_data, 32'h5A5A5A5A);
        check("t4_wr_resp_lit", wr_resp, 2'b00);

        // Reset while waiting for B: everything drops at once and the write never lands.
        set_delays(0, 0, 10, 0, 0);
        saved_ok = model_mem.exists(16);
        saved = saved_ok ? model_mem[16] : 32'h0;
        cnt0 = wr_done_cnt;
        launch(1, 0, 32'h40, 32'hCAFEF00D, 0);
        repeat (2) @(negedge aclk);
        areset = 1'b1;
        #1;
        check("t5_valids_zero", {awvalid, wvalid, arvalid}, 0);
        check("t5_readys_zero", {bready, rready}, 0);
        check("t5_busy_zero", {wr_busy, rd_busy}, 0);
        exp_wr_q.delete();
        if (saved_ok) model_mem[16] = saved;
        else model_mem.delete(16);
        exp_last_rd = '0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        set_delays(0, 0, 0, 0, 0);
        @(negedge aclk);
        check("t5_no_done", wr_done_cnt - cnt0, 0);
        launch(0, 1, 32'h40, 32'h0, 0);
        wait_idle("t5r0", WAIT_BUDGET);
        launch(1, 0, 32'h40, 32'h0BADCAFE, 0);
        wait_idle("t5w", WAIT_BUDGET);
        launch(0, 1, 32'h40, 32'h0, 0);
        wait_idle("t5r", WAIT_BUDGET);
        check("t5_rd_data_lit", rd_data, 32'h0BADCAFE);

        // Randomized mix of delays, addresses, overlap and dropped starts.
        for (int i = 0; i < N_RANDOM; i++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                       $urandom_range(0, 3), $urandom_range(0, 2));
            a = 32'($urandom_range(0, 71)) << 2;
            b = a ^ 32'h4;
            d = $urandom;
            mode = $urandom_range(0, 4);
            case (mode)
                0: launch(1, 0, a, d, 0);
                1: launch(0, 1, a, 32'h0, 0);
                2: begin
                    launch(1, 0, a, d, 0);
                    launch(0, 1, b, 32'h0, $urandom_range(0, 1) == 1);
                end
                3: launch(1, 0, a, d, 1);
                default: begin
                    launch(1, 0, a, d, 0);
                    wait_idle("rnd_w", WAIT_BUDGET);
                    launch(0, 1, a, 32'h0, 0);
                end
            endcase
            wait_idle("rnd", WAIT_BUDGET);
        end

`ifdef AXI_LITE_TIMEOUT_EN
        // Slave never accepts AR: watchdog returns SLVERR.
        set_delays(0, 0, 0, 0, 0);
        ar_never = 1'b1;
        allow_abort = 1'b1;
        exp_rd_q.push_back({2'b10, exp_last_rd});
        start_read = 1'b1;
        addr = 32'h10;
        rd_start_cyc = cyc;
        @(negedge aclk);
        start_read = 1'b0;
        wait_idle("t6", TIMEOUT + 20);
        check("t6_rd_latency", rd_done_cyc - rd_start_cyc, TIMEOUT + 1);
        check("t6_rd_resp_lit", rd_resp, 2'b10);
        ar_never = 1'b0;
        allow_abort = 1'b0;
        @(negedge aclk);
`endif

        check("final_wr_q_empty", exp_wr_q.size(), 0);
        check("final_rd_q_empty", exp_rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(2 * CLOCK_WIDTH * 60000);
        $display("FAIL global_watchdog: actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end
endmodule
